// File: rtl/dcache_wb_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_controller
// Brief    : Direct-mapped write-back / write-allocate data cache that issues
//            whole-line writeback and refill requests to the block glue.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wb_controller #(
   parameter int BLOCKS = 4,
   parameter int SETS   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic [31:0]          cpu_addr,
   input  logic                 cpu_we,
   input  logic [31:0]          cpu_wdata,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_stall,
   output logic                 mem_req,
   output logic [31:0]          mem_addr,
   output logic                 mem_we,
   output logic [BLOCKS*32-1:0] mem_write_block,
   input  logic [BLOCKS*32-1:0] mem_read_block,
   input  logic                 mem_miss
);

   localparam int c_OFF = $clog2(BLOCKS);
   localparam int c_IDX = $clog2(SETS);
   localparam int c_TAG = 32 - c_OFF - c_IDX - 2;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [SETS-1:0]  r_valid;
   logic [SETS-1:0]  r_dirty;
   logic [c_TAG-1:0] r_tag  [SETS];
   logic [31:0]      r_data [SETS][BLOCKS];

   logic [c_OFF-1:0] w_off;
   logic [c_IDX-1:0] w_idx;
   logic [c_TAG-1:0] w_tag;
   logic             w_hit;
   logic             w_wr_hit;
   logic             w_wb_done;
   logic             w_rf_done;
   logic [BLOCKS*32-1:0] w_victim_blk;
   logic             w_unused;

   assign w_off    = cpu_addr[c_OFF+1:2];
   assign w_idx    = cpu_addr[c_OFF+c_IDX+1:c_OFF+2];
   assign w_tag    = cpu_addr[31:c_OFF+c_IDX+2];
   assign w_unused = ^cpu_addr[1:0];
   assign w_hit    = cpu_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

   // Word 0 of the line sits in the least significant lane of the block bus.
   for (genvar g = 0; g < BLOCKS; g++) begin : g_victim
      assign w_victim_blk[g*32 +: 32] = r_data[w_idx][g];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= COMPARE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = 32'd0;
      mem_write_block = '0;
      cpu_stall       = 1'b0;
      cpu_rdata       = 32'd0;
      w_wr_hit        = 1'b0;
      w_wb_done       = 1'b0;
      w_rf_done       = 1'b0;
      case (r_state)
         COMPARE: begin
            if (cpu_req) begin
               if (w_hit) begin
                  if (cpu_we) begin
                     w_wr_hit = 1'b1;
                  end else begin
                     cpu_rdata = r_data[w_idx][w_off];
                  end
               end else begin
                  cpu_stall = 1'b1;
                  w_next    = (r_valid[w_idx] & r_dirty[w_idx]) ? WRITEBACK : REFILL;
               end
            end
         end
         WRITEBACK: begin
            cpu_stall       = 1'b1;
            mem_req         = 1'b1;
            mem_we          = 1'b1;
            mem_addr        = {r_tag[w_idx], w_idx, {(c_OFF+2){1'b0}}};
            mem_write_block = w_victim_blk;
            // Return through COMPARE so mem_req drops for a cycle between transfers.
            if (!mem_miss) begin
               w_wb_done = 1'b1;
               w_next    = COMPARE;
            end
         end
         REFILL: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {w_tag, w_idx, {(c_OFF+2){1'b0}}};
            if (!mem_miss) begin
               w_rf_done = 1'b1;
               w_next    = COMPARE;
            end
         end
         default: begin
            w_next = COMPARE;
         end
      endcase
      if (!reset) begin
         cpu_stall = 1'b0;
         cpu_rdata = 32'd0;
         w_wr_hit  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         if (w_rf_done) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
         end
         if (w_wb_done) begin
            r_dirty[w_idx] <= 1'b0;
         end
         if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; valid qualifies their contents.
   always_ff @(posedge clock) begin
      if (w_rf_done) begin
         r_tag[w_idx] <= w_tag;
         for (int i = 0; i < BLOCKS; i++) begin
            r_data[w_idx][i] <= mem_read_block[i*32 +: 32];
         end
      end
      if (w_wr_hit) begin
         r_data[w_idx][w_off] <= cpu_wdata;
      end
   end

endmodule
`default_nettype wire
